// File: rtl/piso5_tx.sv
// piso5_tx: parallel-in serial-out transmitter with ready/valid and busy/done status
module piso5_tx #(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic             en,
    output logic             s_out,
    output logic             s_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // State, shift register and bit counter; reset aborts any word in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on start in IDLE, shift on each accepted bit, exit at the last bit
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                shreg_d = d_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (en) begin
                shreg_d = LSB_FIRST ? shreg_q >> 1 : shreg_q << 1;
                // Counter holds at WIDTH-1 on exit so it never wraps
                cnt_d   = (cnt_q == CW'(WIDTH - 1)) ? cnt_q : cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs come from registered state only, never from en or start
    assign s_valid = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign s_out   = s_valid & (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
endmodule

// File: tb/tb_piso5_tx.sv
// tb_piso5_tx: scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_piso5_tx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [4:0] d_in = 5'b0;
    logic       s_out_l, s_valid_l, busy_l, done_l;
    logic       s_out_m, s_valid_m, busy_m, done_m;
    int         total = 0;
    int         passed = 0;
    int         fails = 0;
    logic       q_l[$];
    logic       q_m[$];

    piso5_tx #(.WIDTH(5), .LSB_FIRST(1'b1)) u_l (
        .clk(clk), .reset_n(reset_n), .start(start), .d_in(d_in), .en(en),
        .s_out(s_out_l), .s_valid(s_valid_l), .busy(busy_l), .done(done_l)
    );

    piso5_tx #(.WIDTH(5), .LSB_FIRST(1'b0)) u_m (
        .clk(clk), .reset_n(reset_n), .start(start), .d_in(d_in), .en(en),
        .s_out(s_out_m), .s_valid(s_valid_m), .busy(busy_m), .done(done_m)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [4:0] d);
        for (int i = 0; i < 5; i++) begin
            q_l.push_back(d[i]);
            q_m.push_back(d[4-i]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sout_l"}, s_out_l, 0);
        chk({tag, "_valid_l"}, s_valid_l, 0);
        chk({tag, "_busy_l"}, busy_l, 0);
        chk({tag, "_done_l"}, done_l, 0);
        chk({tag, "_sout_m"}, s_out_m, 0);
        chk({tag, "_valid_m"}, s_valid_m, 0);
        chk({tag, "_busy_m"}, busy_m, 0);
        chk({tag, "_done_m"}, done_m, 0);
    endtask

    task automatic chk_status(input string tag, input bit v, input bit d, input bit b);
        chk({tag, "_valid_l"}, s_valid_l, v);
        chk({tag, "_done_l"}, done_l, d);
        chk({tag, "_busy_l"}, busy_l, b);
        chk({tag, "_valid_m"}, s_valid_m, v);
        chk({tag, "_done_m"}, done_m, d);
        chk({tag, "_busy_m"}, busy_m, b);
    endtask

    // Compare serial bits against the scoreboard head, pop on transfer, then advance one edge
    task automatic step();
        if (s_valid_l) begin
            chk("bit_lsb", s_out_l, q_l.size() ? q_l[0] : 1'bx);
            if (en && q_l.size() != 0) void'(q_l.pop_front());
        end else chk("quiet_sout_lsb", s_out_l, 0);
        if (s_valid_m) begin
            chk("bit_msb", s_out_m, q_m.size() ? q_m[0] : 1'bx);
            if (en && q_m.size() != 0) void'(q_m.pop_front());
        end else chk("quiet_sout_msb", s_out_m, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] d, input int stall_len, input bit repulse);
        int sent = 0;
        int st = 0;
        start = 1'b1;
        d_in = d;
        en = 1'b1;
        push_word(d);
        @(posedge clk);
        #1;
        for (int c = 0; c < 8 + stall_len; c++) begin
            start = repulse && c == 2;
            d_in = (repulse && c == 2) ? 5'b00000 : ~d;
            en = !(sent == 2 && st < stall_len);
            if (!en) st++;
            chk_status("word", c < 5 + stall_len, c == 5 + stall_len, c < 6 + stall_len);
            if (s_valid_l && en) sent++;
            step();
        end
        start = 1'b0;
        chk("queue_drained", q_l.size() + q_m.size(), 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("post_reset");

        send(5'b10110, 0, 1'b0);
        send(5'b11001, 3, 1'b0);
        send(5'b10110, 0, 1'b1);

        start = 1'b1;
        d_in = 5'b11111;
        en = 1'b1;
        push_word(5'b11111);
        push_word(5'b11111);
        @(posedge clk);
        #1;
        for (int c = 0; c < 14; c++) begin
            if (c == 12) start = 1'b0;
            chk_status("b2b", c < 5 || (c >= 7 && c < 12), c == 5 || c == 12, c != 6 && c < 13);
            step();
        end
        chk("b2b_drained", q_l.size() + q_m.size(), 0);

        start = 1'b1;
        d_in = 5'b10110;
        en = 1'b1;
        push_word(5'b10110);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk_status("pre_abort", 1'b1, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("abort_async");
        q_l.delete();
        q_m.delete();
        @(posedge clk);
        #1;
        chk_all_zero("abort_held");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("abort_released");

        send(5'b01011, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
